hni_rxflit_crd: RTL and testbench
=================================

// Module: hni_rxflit_crd
// PURPOSE
//  CHI-style receive link stage for the HNI: runs the link activation handshake, issues L-credits,
//  and captures incoming flits. It sits directly upstream of the HNI flit FIFO: it writes accepted
//  flits into the FIFO and watches FIFO pops to recycle slots, so the FIFO never overflows.
// PARAMETERS
//  FLIT_WIDTH  128  flit width in bits
//  MAX_CRD     4    max L-credits outstanding at the transmitter (1..15)
//  FIFO_DEPTH  4    depth of downstream FIFO; must be >= MAX_CRD
// PORTS
//  clk                 in   1           clock
//  rst_n               in   1           async active-low reset
//  rxlinkactivereq_i   in   1           link activation request from transmitter
//  rxlinkactiveack_o   out  1           link activation acknowledge
//  rxflitv_i           in   1           flit valid (consumes one credit)
//  rxflit_i            in   FLIT_WIDTH  flit payload
//  rxlcrdv_o           out  1           one L-credit granted this cycle
//  fifo_wr_en_o        out  1           write strobe to downstream FIFO
//  fifo_wr_data_o      out  FLIT_WIDTH  write data to downstream FIFO
//  fifo_rd_en_i        in   1           downstream FIFO pop (frees one slot)
//  proto_err_o         out  1           sticky: flit received with zero credits outstanding
// BEHAVIOUR
//  Single clock domain. One clock; reset is asynchronous and active-low.
//  Reset: state=STOP, crd_q=0, occ_q=0. All outputs are registered and reset to 0.
//  Link FSM:
//   STOP:       ack=0. Moves to ACTIVATE when req=1.
//   ACTIVATE:   Moves to RUN next cycle if req=1 (ack=1 from that edge); otherwise returns to STOP.
//   RUN:        ack=1. Issues credits. Moves to DEACTIVATE when req=0.
//   DEACTIVATE: ack=1. No new credits. Moves to STOP (ack=0) on the edge where crd_q reaches 0,
//               or stays put while crd_q != 0.
//   A req re-rise during DEACTIVATE is ignored until STOP is reached.
//  crd_q (credits outstanding, 4b):
//   +1 on a grant; -1 on an accepted flit; unchanged when both happen in the same cycle.
//  occ_q (slots used or pending in FIFO, $clog2(FIFO_DEPTH)+1 bits):
//   +1 on an accepted flit; -1 on fifo_rd_en_i; unchanged when both happen in the same cycle.
//  Grant decision uses current register values:
//   grant = (state==RUN) & (crd_q < MAX_CRD) & (crd_q + occ_q < FIFO_DEPTH)
//   Registered: rxlcrdv_o is high the cycle after the decision; crd_q increments on the same edge.
//   At most one credit per cycle.
//  Flit accept:
//   rxflitv_i & (crd_q != 0), in RUN or DEACTIVATE.
//   Captured to fifo_wr_data_o with fifo_wr_en_o=1 exactly one cycle later (1-cycle latency).
//   fifo_wr_data_o holds its last value when wr_en=0.
//  Error:
//   rxflitv_i with crd_q==0, or in STOP/ACTIVATE: flit is dropped (no write, counters unchanged).
//   proto_err_o sets the next cycle and stays set until reset.
//  Invariants:
//   crd_q + occ_q <= FIFO_DEPTH, so no FIFO write ever occurs while the FIFO is full.
//   crd_q <= MAX_CRD.
//   fifo_rd_en_i is assumed only when the FIFO is non-empty; an occ_q underflow is not guarded.
//  Reset mid-operation: all state is cleared immediately.
//   Credits outstanding at the transmitter are forfeit; the link must re-activate.
// TESTING
//  1 Activation: req 0->1 at cyc 0 -> ack=1 at cyc 2; first rxlcrdv_o at cyc 3.
//    With MAX_CRD=4 and no flits: exactly 4 credit pulses on cycles 3..6, then none.
//  2 Flit flow: 4 credits held; send 4 flits back-to-back with payloads 0xA0..0xA3
//    -> 4 FIFO writes, each one cycle after its flit, same order.
//    No new credit while occ_q=4; each fifo_rd_en_i pop -> one new credit about 2 cycles later.
//  3 Simultaneous events: with crd_q=2 and occ_q=1, drive flit + pop + grant in the same cycle
//    -> crd_q stays 2, occ_q stays 1, one write and one credit pulse.
//  4 Deactivation: in RUN with crd_q=3, drop req -> no further credits.
//    ack stays 1 until 3 flits return, then drops the cycle after the last flit.
//  5 Protocol error: flit sent with crd_q=0 -> no fifo_wr_en_o, proto_err_o=1 the next cycle and held.
//    Same outcome for a flit in STOP.
//  6 Async reset asserted in RUN with crd_q=2 -> all outputs 0 immediately, without a clock edge.
//    Re-activation gives a fresh credit count of MAX_CRD.

Source files
------------

// File: rtl/hni_rxflit_crd.sv
// CHI-style receive link stage: link activation FSM, L-credit issue and flit capture
// into the downstream FIFO, with slot tracking so the FIFO can never overflow.
module hni_rxflit_crd #(
    parameter int unsigned FLIT_WIDTH = 128,
    parameter int unsigned MAX_CRD    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxlinkactivereq_i,
    output logic                  rxlinkactiveack_o,
    input  logic                  rxflitv_i,
    input  logic [FLIT_WIDTH-1:0] rxflit_i,
    output logic                  rxlcrdv_o,
    output logic                  fifo_wr_en_o,
    output logic [FLIT_WIDTH-1:0] fifo_wr_data_o,
    input  logic                  fifo_rd_en_i,
    output logic                  proto_err_o
);

    localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SumW = (OccW > 4) ? OccW + 1 : 5;

    typedef enum logic [1:0] {StStop, StActivate, StRun, StDeactivate} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              crd_q, crd_d;
    logic [OccW-1:0]         occ_q, occ_d;
    logic                    ack_q, ack_d;
    logic                    lcrdv_q;
    logic                    wr_en_q;
    logic [FLIT_WIDTH-1:0]   wr_data_q;
    logic                    err_q;
    logic                    grant;
    logic                    accept;
    logic [SumW-1:0]         used;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStop;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving DEACTIVATE looks at the post-update credit count so ack drops
    // on the same edge the last outstanding credit is returned.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop:       if (rxlinkactivereq_i) state_d = StActivate;
            StActivate:   state_d = rxlinkactivereq_i ? StRun : StStop;
            StRun:        if (!rxlinkactivereq_i) state_d = StDeactivate;
            StDeactivate: if (crd_d == 4'd0) state_d = StStop;
            default:      state_d = StStop;
        endcase
    end

    always_comb begin
        used   = SumW'(crd_q) + SumW'(occ_q);
        grant  = (state_q == StRun) && (crd_q < 4'(MAX_CRD)) && (used < SumW'(FIFO_DEPTH));
        accept = rxflitv_i && (crd_q != 4'd0) &&
                 ((state_q == StRun) || (state_q == StDeactivate));
        ack_d  = (state_d == StRun) || (state_d == StDeactivate);
    end

    always_comb begin
        crd_d = crd_q + 4'(grant) - 4'(accept);
        occ_d = occ_q + OccW'(accept) - OccW'(fifo_rd_en_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd_q     <= '0;
            occ_q     <= '0;
            ack_q     <= 1'b0;
            lcrdv_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            crd_q   <= crd_d;
            occ_q   <= occ_d;
            ack_q   <= ack_d;
            lcrdv_q <= grant;
            wr_en_q <= accept;
            if (accept) begin
                wr_data_q <= rxflit_i;
            end
            // Any flit that is not accepted is a protocol violation and is dropped.
            if (rxflitv_i && !accept) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rxlinkactiveack_o = ack_q;
    assign rxlcrdv_o         = lcrdv_q;
    assign fifo_wr_en_o      = wr_en_q;
    assign fifo_wr_data_o    = wr_data_q;
    assign proto_err_o       = err_q;

endmodule

// File: tb/tb_hni_rxflit_crd.sv
// Randomised bench for hni_rxflit_crd: cycle-level reference model plus a write-data
// scoreboard drained by an independent monitor.
module tb_hni_rxflit_crd;

    localparam int unsigned FW    = 128;
    localparam int          MAXC  = 4;
    localparam int          DEPTH = 4;
    localparam int LStop = 0, LAct = 1, LRun = 2, LDeact = 3;

    logic          clk;
    logic          rst_n;
    logic          rxlinkactivereq_i;
    logic          rxlinkactiveack_o;
    logic          rxflitv_i;
    logic [FW-1:0] rxflit_i;
    logic          rxlcrdv_o;
    logic          fifo_wr_en_o;
    logic [FW-1:0] fifo_wr_data_o;
    logic          fifo_rd_en_i;
    logic          proto_err_o;

    hni_rxflit_crd #(
        .FLIT_WIDTH (FW),
        .MAX_CRD    (MAXC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rxlinkactivereq_i (rxlinkactivereq_i),
        .rxlinkactiveack_o (rxlinkactiveack_o),
        .rxflitv_i         (rxflitv_i),
        .rxflit_i          (rxflit_i),
        .rxlcrdv_o         (rxlcrdv_o),
        .fifo_wr_en_o      (fifo_wr_en_o),
        .fifo_wr_data_o    (fifo_wr_data_o),
        .fifo_rd_en_i      (fifo_rd_en_i),
        .proto_err_o       (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [FW-1:0] exp_q[$];

    // Reference model: link phase, credits held by the transmitter, FIFO slots in use.
    int   m_link = LStop;
    int   m_crd  = 0;
    int   m_occ  = 0;
    logic m_ack  = 1'b0;
    logic m_lcrdv = 1'b0;
    logic m_err  = 1'b0;
    logic m_wr   = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b, want %b", name, $time, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_link = LStop; m_crd = 0; m_occ = 0;
        m_ack = 1'b0; m_lcrdv = 1'b0; m_err = 1'b0; m_wr = 1'b0;
        exp_q.delete();
    endtask

    // One clock: check outputs against the model, drive new inputs, advance the model.
    task automatic cycle(input logic req, input logic fv, input logic [FW-1:0] fl,
                         input logic pop);
        bit acc, grant;
        int ncrd, nlink;
        @(negedge clk);
        chk1("ack", rxlinkactiveack_o, m_ack);
        chk1("lcrdv", rxlcrdv_o, m_lcrdv);
        chk1("proto_err", proto_err_o, m_err);
        chk1("wr_en", fifo_wr_en_o, m_wr);
        rxlinkactivereq_i = req;
        rxflitv_i         = fv;
        rxflit_i          = fl;
        fifo_rd_en_i      = pop;
        acc   = fv && (m_crd > 0) && (m_link == LRun || m_link == LDeact);
        grant = (m_link == LRun) && (m_crd < MAXC) && (m_crd + m_occ < DEPTH);
        ncrd  = m_crd + int'(grant) - int'(acc);
        case (m_link)
            LStop:   nlink = req ? LAct : LStop;
            LAct:    nlink = req ? LRun : LStop;
            LRun:    nlink = req ? LRun : LDeact;
            default: nlink = (ncrd == 0) ? LStop : LDeact;
        endcase
        if (acc) exp_q.push_back(fl);
        m_err   = m_err | (fv && !acc);
        m_wr    = acc;
        m_lcrdv = grant;
        m_ack   = (nlink == LRun) || (nlink == LDeact);
        m_occ   = m_occ + int'(acc) - int'(pop);
        m_crd   = ncrd;
        m_link  = nlink;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && fifo_wr_en_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected @%0t: got data %0h, want no write",
                             $time, fifo_wr_data_o);
                end else begin
                    chkw("wr_data", fifo_wr_data_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic req;
        int   guard;
        rst_n = 1'b0;
        rxlinkactivereq_i = 1'b0;
        rxflitv_i = 1'b0;
        rxflit_i = '0;
        fifo_rd_en_i = 1'b0;
        #3;
        chk1("rst_ack", rxlinkactiveack_o, 1'b0);
        chk1("rst_lcrdv", rxlcrdv_o, 1'b0);
        chk1("rst_wr_en", fifo_wr_en_o, 1'b0);
        chkw("rst_wr_data", fifo_wr_data_o, '0);
        chk1("rst_err", proto_err_o, 1'b0);
        #9 rst_n = 1'b1;

        // Activation and the initial burst of MAX_CRD credits.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        // Four back-to-back flits using all held credits, then pops recycle slots.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, FW'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0);

        req = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req = !req;
            cycle(req, (m_crd > 0) && ($urandom_range(0, 1) == 1), rand_flit(),
                  (m_occ > 0) && ($urandom_range(0, 2) != 0));
        end

        // Deactivate: return all credits so the link reaches STOP.
        guard = 0;
        while (m_link != LStop && guard < 200) begin
            cycle(1'b0, m_crd > 0, rand_flit(), m_occ > 0);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL deactivate_timeout: got link phase %0d, want STOP", m_link);
        end
        while (m_occ > 0) cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b0);

        // Flit while stopped: dropped and flagged.
        cycle(1'b0, 1'b1, rand_flit(), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);

        // Reactivate and reset asynchronously with two credits held.
        guard = 0;
        while (m_crd != 2 && guard < 20) begin
            cycle(1'b1, 1'b0, '0, 1'b0);
            guard++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        rxlinkactivereq_i = 1'b0;
        rxflitv_i = 1'b0;
        fifo_rd_en_i = 1'b0;
        #1;
        chk1("async_ack", rxlinkactiveack_o, 1'b0);
        chk1("async_lcrdv", rxlcrdv_o, 1'b0);
        chk1("async_wr_en", fifo_wr_en_o, 1'b0);
        chkw("async_wr_data", fifo_wr_data_o, '0);
        chk1("async_err", proto_err_o, 1'b0);
        model_reset();
        #1 rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (m_crd > 0) && ($urandom_range(0, 1) == 1), rand_flit(),
                  (m_occ > 0) && ($urandom_range(0, 1) == 1));
        end
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_writes: got %0d outstanding, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
